// File: rtl/rv32i_types.sv
// rv32i_types -- shared widths, types and FSM encoding for the cache-line
// adaptor that sits between the L2-side arbiter (256-bit lines) and a
// 64-bit burst memory.
//
// Contents:
//   LINE_BITS / BEAT_BITS / BEATS   line geometry (256 = 4 x 64)
//   rv32i_word, rv32i_cache_line    address word and full cache line types
//   adaptor_state_e                 IDLE / READ / WRITE / DONE
//   align_line()                    clears the byte-offset bits of an address
package rv32i_types;

  localparam int LINE_BITS   = 256;
  localparam int BEAT_BITS   = 64;
  localparam int BEATS       = LINE_BITS / BEAT_BITS;
  localparam int CNT_BITS    = $clog2(BEATS);
  localparam int BEAT_SHIFT  = $clog2(BEAT_BITS);
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

  typedef logic [31:0]          rv32i_word;
  typedef logic [LINE_BITS-1:0] rv32i_cache_line;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

  // Lines are 32 bytes, so the low five address bits select a byte inside
  // the line and never reach memory.
  function automatic rv32i_word align_line(input rv32i_word addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor -- converts one 256-bit line read/write request into a
// four-beat 64-bit memory burst, lowest beat first.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   line_address  (in 32)   line request address from the arbiter
//   line_wdata    (in 256)  line write data
//   line_read/line_write    line requests, held high until line_resp
//   line_rdata    (out 256) assembled read line
//   line_resp     (out 1)   one-cycle completion pulse
//   burst_address (out 32)  line-aligned memory address (0 when idle)
//   burst_wdata   (out 64)  current write beat
//   burst_read/burst_write  memory burst requests
//   burst_rdata   (in 64)   current read beat
//   burst_resp    (in 1)    memory beat accepted / beat valid strobe
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          line_address,
  input  logic [LINE_BITS-1:0] line_wdata,
  input  logic                 line_read,
  input  logic                 line_write,
  output logic [LINE_BITS-1:0] line_rdata,
  output logic                 line_resp,
  output logic [31:0]          burst_address,
  output logic [BEAT_BITS-1:0] burst_wdata,
  output logic                 burst_read,
  output logic                 burst_write,
  input  logic [BEAT_BITS-1:0] burst_rdata,
  input  logic                 burst_resp
);

  adaptor_state_e        state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  // One buffer serves both directions: it collects beats during a read and
  // holds the latched write data during a write. A write therefore replaces
  // whatever the previous read left on line_rdata.
  logic [LINE_BITS-1:0]  line_q, line_d;

  // Bit offset of the current beat inside the line: cnt * 64.
  logic [CNT_BITS+BEAT_SHIFT-1:0] beat_lsb;
  logic                           last_beat;

  assign beat_lsb  = {cnt_q, {BEAT_SHIFT{1'b0}}};
  assign last_beat = (cnt_q == CNT_BITS'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        // Read has priority if both requests are raised together.
        if (line_read) begin
          addr_d  = align_line(line_address);
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (line_write) begin
          addr_d  = align_line(line_address);
          line_d  = line_wdata;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (burst_resp) begin
          line_d[beat_lsb +: BEAT_BITS] = burst_rdata;
          cnt_d = cnt_q + CNT_BITS'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (burst_resp) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  assign line_rdata    = line_q;
  assign line_resp     = (state_q == ST_DONE);
  assign burst_read    = (state_q == ST_READ);
  assign burst_write   = (state_q == ST_WRITE);
  assign burst_address = (burst_read || burst_write) ? addr_q : '0;
  assign burst_wdata   = burst_write ? line_q[beat_lsb +: BEAT_BITS] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: the stimulus process pushes the
// expected outcome of each line request, a memory responder answers bursts
// from a line-addressed memory array, and a monitor checks every beat and
// every line_resp against the queued expectation.
module tb_cacheline_adaptor;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_wdata = '0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  cacheline_adaptor dut (
    .clk(clk), .rst_n(rst_n),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_read(line_read), .line_write(line_write),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_read;
    logic [31:0]  addr;
    logic [255:0] data;
    int           issue_cyc;
    int           exp_lat;
  } txn_t;

  txn_t         exp_q[$];
  logic [255:0] mem [logic [31:0]];
  int           gap_mode = 0;   // -1: random 0..3 idle cycles per beat
  bit           noise_en = 1'b0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [63:0] slot(input logic [255:0] l, input int i);
    if (i < 0 || i > 3) return '0;
    return l[i*64 +: 64];
  endfunction

  // ---------------- memory responder ----------------
  int rbeat = 0;
  int wait_cnt = -1;
  bit armed = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (!(burst_read || burst_write)) begin
      armed = 1'b0; rbeat = 0; wait_cnt = -1;
      // Junk strobes and data while no burst is requested must be ignored.
      burst_resp  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      burst_rdata = {$urandom, $urandom};
    end else begin
      if (armed && burst_resp) begin
        rbeat++;
        wait_cnt = -1;
      end
      armed = 1'b1;
      burst_resp = 1'b0;
      if (wait_cnt < 0) wait_cnt = (gap_mode >= 0) ? gap_mode : $urandom_range(0, 3);
      if (wait_cnt == 0) begin
        burst_resp = 1'b1;
        wait_cnt = -1;
        if (mem.exists(burst_address) && rbeat < 4) burst_rdata = slot(mem[burst_address], rbeat);
        else burst_rdata = {$urandom, $urandom};
      end else begin
        wait_cnt--;
        burst_rdata = {$urandom, $urandom};
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   mbeat = 0;
  bit   active = 1'b0;
  int   ntx = 0;
  txn_t mt;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      mbeat = 0;
      active = 1'b0;
      continue;
    end
    if (burst_read || burst_write) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_burst read=%0b write=%0b required=none", burst_read, burst_write);
      end else begin
        active = 1'b1;
        if (burst_resp) begin
          chk("burst_kind", {254'd0, burst_read, burst_write}, exp_q[0].is_read ? 256'd2 : 256'd1);
          chk("burst_address", burst_address, exp_q[0].addr);
          if (!exp_q[0].is_read) chk("burst_wdata", burst_wdata, slot(exp_q[0].data, mbeat));
          mbeat++;
        end
      end
    end else if (active && !line_resp) begin
      chk("burst_held", {255'd0, burst_read | burst_write}, 256'd1);
    end
    if (line_resp) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_line_resp actual=1 required=0");
      end else begin
        mt = exp_q.pop_front();
        chk("done_no_burst", {254'd0, burst_read, burst_write}, 256'd0);
        chk("beats_before_resp", mbeat, 4);
        if (mt.is_read) chk("line_rdata", line_rdata, mt.data);
        if (mt.exp_lat >= 0) chk("latency", cyc - mt.issue_cyc, mt.exp_lat);
        ntx++;
        $display("txn %0d %s addr=%h latency=%0d", ntx, mt.is_read ? "read" : "write",
                 mt.addr, cyc - mt.issue_cyc);
      end
      mbeat = 0;
      active = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  // op: 0 read, 1 write, 2 read and write together. Called at posedge+1.
  task automatic issue(input int op, input logic [31:0] a, input logic [255:0] wd, input int lat);
    txn_t t;
    logic [31:0] al;
    int n;
    al = a & 32'hFFFF_FFE0;
    t.is_read = (op != 1);
    t.addr = al;
    t.issue_cyc = cyc;
    t.exp_lat = lat;
    if (t.is_read) begin
      if (!mem.exists(al)) mem[al] = rand_line();
      t.data = mem[al];
    end else begin
      t.data = wd;
      mem[al] = wd;
    end
    exp_q.push_back(t);
    line_address = a;
    line_wdata = wd;
    line_read = (op != 1);
    line_write = (op != 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (line_resp) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL timeout_line_resp addr=%h actual=no_resp required=resp", a);
        break;
      end
      @(posedge clk); #1;
      // Line-side inputs are scrambled mid-burst; only the IDLE sample counts.
      line_address = $urandom;
      line_wdata = rand_line();
    end
    @(posedge clk); #1;
    line_read = 1'b0;
    line_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_line_resp"}, {255'd0, line_resp}, 256'd0);
    chk({tag, "_burst_read"}, {255'd0, burst_read}, 256'd0);
    chk({tag, "_burst_write"}, {255'd0, burst_write}, 256'd0);
    chk({tag, "_burst_address"}, burst_address, 256'd0);
    chk({tag, "_line_rdata"}, line_rdata, 256'd0);
  endtask

  logic [255:0] wline;
  logic [31:0]  ra;
  int           op;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed read with back-to-back beats.
    mem[32'h0000_1220] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    gap_mode = 0;
    issue(0, 32'h0000_1234, '0, 5);

    // The read line must survive idle cycles with junk on the memory side.
    noise_en = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rdata_hold", line_rdata, mem[32'h0000_1220]);
    @(posedge clk); #1;

    // Directed write, then read it back through a stalled memory.
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    issue(1, 32'h0000_8040, wline, 5);
    gap_mode = 3;
    issue(0, 32'h0000_805F, '0, 17);

    // Read and write raised together: the read must win.
    gap_mode = 0;
    issue(2, 32'h0000_2000, rand_line(), 5);

    // Reset after two read beats have been stored.
    mem[32'h0000_3000] = rand_line();
    begin
      txn_t t;
      t.is_read = 1'b1; t.addr = 32'h0000_3000; t.data = mem[32'h0000_3000];
      t.issue_cyc = cyc; t.exp_lat = -1;
      exp_q.push_back(t);
    end
    line_address = 32'h0000_3000;
    line_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    line_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midburst_reset");
    @(posedge clk); #1;
    mem[32'h0000_3000] = rand_line();
    issue(0, 32'h0000_3008, '0, 5);

    // Back-to-back read then write with no idle cycle in between.
    gap_mode = -1;
    issue(0, 32'h0000_4000, '0, -1);
    issue(1, 32'h0000_4020, rand_line(), -1);

    // Random traffic over a small pool of lines so writes are read back.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      ra = 32'h0001_0000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      gap_mode = ($urandom_range(0, 1) == 0) ? 0 : -1;
      issue(op, ra, rand_line(), (gap_mode == 0) ? 5 : -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
